// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle ALU controller.
// One opcode per start/busy/done transaction; rotates repeat N times.
module alu_op_sequencer #(
  parameter int ROT_CNT_W = 3
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iStart,
  input  logic [3:0]           iOpcode,
  input  logic [ROT_CNT_W-1:0] iRotCount,
  input  logic [7:0]           iALU,
  output logic                 oAdd,
  output logic                 oSub,
  output logic                 oAND,
  output logic                 oOR,
  output logic                 oXOR,
  output logic                 oInc,
  output logic                 oDec,
  output logic                 oRotL,
  output logic                 oRotR,
  output logic                 oLoadB,
  output logic                 oLoadAcc,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oIllegal,
  output logic                 oZero,
  output logic                 oSign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [3:0]             r_op;
  logic [ROT_CNT_W-1:0]   r_cnt;
  logic                   w_rot;
  logic                   w_illegal;
  logic                   w_again;
  logic                   w_ctl_en;

  assign w_rot     = (r_op == 4'd7) || (r_op == 4'd8);
  assign w_illegal = (r_op > 4'd8);
  assign w_again   = w_rot && (r_cnt > ROT_CNT_W'(1));

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_op  <= '0;
      r_cnt <= '0;
    end else if (r_state == S_IDLE && iStart) begin
      r_op  <= iOpcode;
      r_cnt <= iRotCount;
    end else if (r_state == S_WB && w_again) begin
      r_cnt <= r_cnt - ROT_CNT_W'(1);
    end
  end

  // Flags follow the ALU result only on the accumulator write.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      oZero <= 1'b0;
      oSign <= 1'b0;
    end else if (r_state == S_WB) begin
      oZero <= (iALU == 8'h00);
      oSign <= iALU[7];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (iStart) begin
          if (iOpcode <= 4'd4) begin
            w_next = S_LOAD_B;
          end else if (iOpcode <= 4'd6) begin
            w_next = S_EXEC;
          end else if (iOpcode <= 4'd8) begin
            w_next = (iRotCount != '0) ? S_EXEC : S_DONE;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_LOAD_B: w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = w_again ? S_EXEC : S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_ctl_en = (r_state == S_EXEC) || (r_state == S_WB);

  always_comb begin
    oAdd  = 1'b0;
    oSub  = 1'b0;
    oAND  = 1'b0;
    oOR   = 1'b0;
    oXOR  = 1'b0;
    oInc  = 1'b0;
    oDec  = 1'b0;
    oRotL = 1'b0;
    oRotR = 1'b0;
    if (w_ctl_en) begin
      case (r_op)
        4'd0:    oAdd  = 1'b1;
        4'd1:    oSub  = 1'b1;
        4'd2:    oAND  = 1'b1;
        4'd3:    oOR   = 1'b1;
        4'd4:    oXOR  = 1'b1;
        4'd5:    oInc  = 1'b1;
        4'd6:    oDec  = 1'b1;
        4'd7:    oRotL = 1'b1;
        4'd8:    oRotR = 1'b1;
        default: ;
      endcase
    end
  end

  assign oLoadB   = (r_state == S_LOAD_B);
  assign oLoadAcc = (r_state == S_WB);
  assign oBusy    = (r_state != S_IDLE);
  assign oDone    = (r_state == S_DONE);
  assign oIllegal = (r_state == S_DONE) && w_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: cycle traces from an opcode-level model,
// compared against the sequencer outputs and flags.
module tb_alu_op_sequencer;

  logic       iClock;
  logic       iReset;
  logic       iStart;
  logic [3:0] iOpcode;
  logic [2:0] iRotCount;
  logic [7:0] iALU;
  logic oAdd, oSub, oAND, oOR, oXOR, oInc, oDec, oRotL, oRotR;
  logic oLoadB, oLoadAcc, oBusy, oDone, oIllegal, oZero, oSign;

  int nerr;
  int nchk;
  logic exp_z;
  logic exp_s;

  alu_op_sequencer #(.ROT_CNT_W(3)) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart),
    .iOpcode(iOpcode), .iRotCount(iRotCount), .iALU(iALU),
    .oAdd(oAdd), .oSub(oSub), .oAND(oAND), .oOR(oOR),
    .oXOR(oXOR), .oInc(oInc), .oDec(oDec),
    .oRotL(oRotL), .oRotR(oRotR),
    .oLoadB(oLoadB), .oLoadAcc(oLoadAcc), .oBusy(oBusy),
    .oDone(oDone), .oIllegal(oIllegal),
    .oZero(oZero), .oSign(oSign)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  // {Add,Sub,AND,OR,XOR,Inc,Dec,RotL,RotR,LoadB,LoadAcc,Busy,Done,Illegal}
  function automatic logic [13:0] obs();
    return {oAdd, oSub, oAND, oOR, oXOR, oInc, oDec, oRotL, oRotR,
            oLoadB, oLoadAcc, oBusy, oDone, oIllegal};
  endfunction

  localparam logic [13:0] B_LDB  = 14'b00000000010000;
  localparam logic [13:0] B_ACC  = 14'b00000000001000;
  localparam logic [13:0] B_BUSY = 14'b00000000000100;
  localparam logic [13:0] B_DONE = 14'b00000000000010;
  localparam logic [13:0] B_ILL  = 14'b00000000000001;

  // Expected per-cycle outputs for one transaction, from opcode rules.
  function automatic void build(input int op, input int cnt,
                                output logic [13:0] q[$]);
    logic [13:0] ctl;
    q = {};
    ctl = (op <= 8) ? (14'b1 << (13 - op)) : 14'b0;
    if (op > 8) begin
      q.push_back(B_BUSY | B_DONE | B_ILL);
    end else if (op <= 4) begin
      q.push_back(B_BUSY | B_LDB);
      q.push_back(B_BUSY | ctl);
      q.push_back(B_BUSY | ctl | B_ACC);
      q.push_back(B_BUSY | B_DONE);
    end else if (op <= 6) begin
      q.push_back(B_BUSY | ctl);
      q.push_back(B_BUSY | ctl | B_ACC);
      q.push_back(B_BUSY | B_DONE);
    end else begin
      for (int i = 0; i < cnt; i++) begin
        q.push_back(B_BUSY | ctl);
        q.push_back(B_BUSY | ctl | B_ACC);
      end
      q.push_back(B_BUSY | B_DONE);
    end
  endfunction

  // poke: cycle in which a stray iStart (AND) is raised; 0 = none.
  // alu: bit 8 set forces iALU to alu[7:0], otherwise random.
  task automatic run_op(input string name, input int op, input int cnt,
                        input int poke, input logic [8:0] alu);
    logic [13:0] q[$];
    logic [13:0] want;
    logic        pend;
    logic [7:0]  pval;
    build(op, cnt, q);
    pend = 1'b0;
    pval = 8'h00;
    iOpcode   = 4'(op);
    iRotCount = 3'(cnt);
    iStart    = 1'b1;
    for (int k = 0; k <= q.size(); k++) begin
      @(posedge iClock);
      #1;
      if (k + 1 == poke) begin
        iStart  = 1'b1;
        iOpcode = 4'd2;
      end else begin
        iStart = 1'b0;
      end
      if (pend) begin
        exp_z = (pval == 8'h00);
        exp_s = pval[7];
        pend  = 1'b0;
      end
      want = (k < q.size()) ? q[k] : 14'b0;
      nchk++;
      if (obs() !== want) begin
        nerr++;
        $display("FAIL %s cyc%0d outputs: got %b want %b",
                 name, k + 1, obs(), want);
      end
      nchk++;
      if ({oZero, oSign} !== {exp_z, exp_s}) begin
        nerr++;
        $display("FAIL %s cyc%0d flags: got zs=%b%b want %b%b",
                 name, k + 1, oZero, oSign, exp_z, exp_s);
      end
      iALU = alu[8] ? alu[7:0] : 8'($urandom);
      if (want[3]) begin
        pend = 1'b1;
        pval = iALU;
      end
    end
  endtask

  task automatic test_reset();
    iReset = 1'b0;
    #12;
    nchk++;
    if ({obs(), oZero, oSign} !== 16'b0) begin
      nerr++;
      $display("FAIL reset_state: got %b want 0", {obs(), oZero, oSign});
    end
    @(negedge iClock);
    iReset = 1'b1;
    @(posedge iClock);
    #1;
    exp_z = 1'b0;
    exp_s = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic saw_done;
    run_op("pre_reset_xor", 4, 0, 0, 9'h100);
    iOpcode = 4'd0;
    iStart  = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0;
    @(posedge iClock); #1;
    nchk++;
    if (oAdd !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid_exec: got oAdd=%b want 1", oAdd);
    end
    #2;
    iReset = 1'b0;
    #1;
    nchk++;
    if ({obs(), oZero, oSign} !== 16'b0) begin
      nerr++;
      $display("FAIL reset_async: got %b want 0", {obs(), oZero, oSign});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge iClock); #1;
      if (oDone) saw_done = 1'b1;
    end
    @(negedge iClock);
    iReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge iClock); #1;
      if (oDone) saw_done = 1'b1;
    end
    exp_z = 1'b0;
    exp_s = 1'b0;
    nchk++;
    if (saw_done !== 1'b0 || oBusy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release: got done=%b busy=%b want 0 0",
               saw_done, oBusy);
    end
  endtask

  task automatic test_add_zero();
    run_op("add_zero", 0, 0, 0, 9'h100);
    nchk++;
    if ({oZero, oSign} !== 2'b10) begin
      nerr++;
      $display("FAIL add_flags: got %b%b want 10", oZero, oSign);
    end
  endtask

  task automatic test_dec_sign();
    run_op("dec_sign", 6, 0, 0, 9'h1FF);
    nchk++;
    if ({oZero, oSign} !== 2'b01) begin
      nerr++;
      $display("FAIL dec_flags: got %b%b want 01", oZero, oSign);
    end
  endtask

  task automatic test_rotate();
    run_op("rol3", 7, 3, 0, 9'h040);
    run_op("ror7", 8, 7, 0, 9'h000);
  endtask

  task automatic test_illegal_and_rot0();
    run_op("add_setflags", 0, 0, 0, 9'h180);
    run_op("illegal12", 12, 0, 0, 9'h100);
    run_op("ror_cnt0", 8, 0, 0, 9'h100);
    nchk++;
    if ({oZero, oSign} !== 2'b01) begin
      nerr++;
      $display("FAIL flags_hold: got %b%b want 01", oZero, oSign);
    end
  endtask

  task automatic test_busy_ignore();
    run_op("sub_poke", 1, 0, 2, 9'h000);
  endtask

  task automatic test_back_to_back();
    int op;
    int cnt;
    for (int t = 0; t < 40; t++) begin
      op  = int'($urandom_range(0, 15));
      cnt = int'($urandom_range(0, 7));
      run_op("rand", op, cnt, int'($urandom_range(0, 3)), 9'h000);
    end
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    exp_z = 1'b0;
    exp_s = 1'b0;
    iStart = 1'b0;
    iOpcode = 4'd0;
    iRotCount = 3'd0;
    iALU = 8'h00;
    test_reset();
    test_reset_mid_op();
    test_add_zero();
    test_dec_sign();
    test_rotate();
    test_illegal_and_rot0();
    test_busy_ignore();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
